// File: rtl/addsub_restoring_divider.sv
// ---------------------------------------------------------------------------
// addsub_restoring_divider
//
// Sequential unsigned restoring divider. One WIDTH+1-bit ripple add/sub path
// is shared across all iterations, with its S input tied to subtract. The
// divider performs one trial subtraction per clock for WIDTH clocks, then
// publishes the quotient and remainder together with a one-cycle done strobe.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        asynchronous, active-high reset
//   start_i      request; sampled only while ready_o=1
//   a_i          dividend (unsigned), captured when start is accepted
//   b_i          divisor  (unsigned), captured when start is accepted
//   ready_o      high in IDLE only
//   done_o       one-cycle pulse when the results become valid
//   quotient_o   quotient result register
//   remainder_o  remainder result register
//   div_zero_o   set with done_o when the captured divisor was zero
// ---------------------------------------------------------------------------
module addsub_restoring_divider #(
   parameter int WIDTH = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             ready_o,
   output logic             done_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             div_zero_o
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   // Ripple-carry adder/subtractor: with sub=1 it computes x + ~y + 1.
   function automatic logic [WIDTH:0] ripple_addsub(
      input logic [WIDTH:0] x,
      input logic [WIDTH:0] y,
      input logic           sub
   );
      logic [WIDTH:0] sum;
      logic           carry;
      logic           yb;
      carry = sub;
      for (int i = 0; i <= WIDTH; i++) begin
         yb     = y[i] ^ sub;
         sum[i] = x[i] ^ yb ^ carry;
         carry  = (x[i] & yb) | (x[i] & carry) | (yb & carry);
      end
      return sum;
   endfunction

   state_t           state_q;
   logic [WIDTH:0]   r_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] d_q;
   logic [CW-1:0]    cnt_q;
   logic             dz_pend_q;
   logic             ready_q;
   logic             done_q;
   logic [WIDTH-1:0] quot_q;
   logic [WIDTH-1:0] rem_q;
   logic             dz_q;

   logic [WIDTH:0]   rs_s;
   logic [WIDTH:0]   t_s;
   logic [WIDTH:0]   r_d;
   logic [WIDTH-1:0] q_d;

   // One restoring iteration: shift, trial subtract, keep or restore.
   always_comb begin
      rs_s = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
      t_s  = ripple_addsub(rs_s, {1'b0, d_q}, 1'b1);
      r_d  = rs_s;
      q_d  = {q_q[WIDTH-2:0], 1'b0};
      // The partial remainder is always below the divisor, so the top bit of
      // the trial result is a clean borrow flag.
      if (t_s[WIDTH] == 1'b0) begin
         r_d = t_s;
         q_d = {q_q[WIDTH-2:0], 1'b1};
      end else begin
         r_d = rs_s;
         q_d = {q_q[WIDTH-2:0], 1'b0};
      end
   end

   // Sequencer FSM with the datapath and result registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         r_q       <= {(WIDTH+1){1'b0}};
         q_q       <= {WIDTH{1'b0}};
         d_q       <= {WIDTH{1'b0}};
         cnt_q     <= {CW{1'b0}};
         dz_pend_q <= 1'b0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
         quot_q    <= {WIDTH{1'b0}};
         rem_q     <= {WIDTH{1'b0}};
         dz_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  state_q <= ST_RUN;
                  ready_q <= 1'b0;
                  d_q     <= b_i;
                  q_q     <= a_i;
                  r_q     <= {(WIDTH+1){1'b0}};
                  // A zero divisor skips the iterations: one pass through
                  // RUN with count=0 keeps its DONE timing one edge later.
                  if (b_i == {WIDTH{1'b0}}) begin
                     dz_pend_q <= 1'b1;
                     cnt_q     <= {CW{1'b0}};
                  end else begin
                     dz_pend_q <= 1'b0;
                     cnt_q     <= CW'(WIDTH-1);
                  end
               end else begin
                  ready_q <= 1'b1;
               end
            end

            ST_RUN: begin
               if (!dz_pend_q) begin
                  r_q <= r_d;
                  q_q <= q_d;
               end else begin
                  r_q <= r_q;
                  q_q <= q_q;
               end
               if (cnt_q == {CW{1'b0}}) begin
                  state_q <= ST_FIN;
                  done_q  <= 1'b1;
                  if (dz_pend_q) begin
                     quot_q <= {WIDTH{1'b1}};
                     rem_q  <= q_q;
                     dz_q   <= 1'b1;
                  end else begin
                     quot_q <= q_d;
                     rem_q  <= r_d[WIDTH-1:0];
                     dz_q   <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end

            ST_FIN: begin
               state_q   <= ST_IDLE;
               done_q    <= 1'b0;
               ready_q   <= 1'b1;
               dz_pend_q <= 1'b0;
            end

            default: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign ready_o     = ready_q;
   assign done_o      = done_q;
   assign quotient_o  = quot_q;
   assign remainder_o = rem_q;
   assign div_zero_o  = dz_q;

endmodule

// File: tb/tb_addsub_restoring_divider.sv
// ---------------------------------------------------------------------------
// Directed testbench for addsub_restoring_divider (WIDTH=6).
// ---------------------------------------------------------------------------
module tb_addsub_restoring_divider;

   logic       clk;
   logic       rst;
   logic       start;
   logic [5:0] a;
   logic [5:0] b;
   logic       ready;
   logic       done;
   logic [5:0] quot;
   logic [5:0] rem;
   logic       dz;

   int n_checks = 0;
   int n_fail   = 0;

   addsub_restoring_divider #(.WIDTH(6)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .a_i         (a),
      .b_i         (b),
      .ready_o     (ready),
      .done_o      (done),
      .quotient_o  (quot),
      .remainder_o (rem),
      .div_zero_o  (dz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // One complete operation: accept, wait for DONE, check results and handshake.
   task automatic run_div(input logic [5:0] av, input logic [5:0] bv,
                          input logic [5:0] eq, input logic [5:0] er,
                          input logic edz, input int elat, input string tag);
      int  lat;
      bit  ready_seen;
      @(negedge clk);
      start = 1'b1; a = av; b = bv;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      ready_seen = 1'b0;
      if (ready) ready_seen = 1'b1;
      while (lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (ready) ready_seen = 1'b1;
         if (done) break;
      end
      check_val({tag, "_lat"}, lat, elat);
      check_val({tag, "_ready_low"}, ready_seen, 0);
      check_val({tag, "_q"}, quot, eq);
      check_val({tag, "_r"}, rem, er);
      check_val({tag, "_dz"}, dz, edz);
      @(posedge clk); #1;
      check_val({tag, "_done_1cyc"}, done, 0);
      check_val({tag, "_ready_back"}, ready, 1);
   endtask

   logic [5:0] hq_a [3] = '{6'd45, 6'd20, 6'd50};
   logic [5:0] hq_b [3] = '{6'd6,  6'd0,  6'd7};
   logic [5:0] hq_q [3] = '{6'd7,  6'd63, 6'd7};
   logic [5:0] hq_r [3] = '{6'd3,  6'd20, 6'd1};
   logic       hq_z [3] = '{1'b0,  1'b1,  1'b0};

   initial begin
      int ndone;
      int idx;
      int cyc;
      logic [5:0] ea;
      logic [5:0] eb;

      rst = 1'b1; start = 1'b0; a = 6'd0; b = 6'd0;
      #22;
      check_val("rst_ready", ready, 1);
      check_val("rst_done", done, 0);
      check_val("rst_q", quot, 0);
      check_val("rst_r", rem, 0);
      check_val("rst_dz", dz, 0);
      rst = 1'b0;

      // Directed vectors.
      run_div(6'd45, 6'd6,  6'd7,  6'd3,  1'b0, 6, "d45_6");
      run_div(6'd63, 6'd1,  6'd63, 6'd0,  1'b0, 6, "d63_1");
      run_div(6'd63, 6'd63, 6'd1,  6'd0,  1'b0, 6, "d63_63");
      run_div(6'd0,  6'd5,  6'd0,  6'd0,  1'b0, 6, "d0_5");
      run_div(6'd5,  6'd9,  6'd0,  6'd5,  1'b0, 6, "d5_9");
      run_div(6'd20, 6'd0,  6'd63, 6'd20, 1'b1, 1, "d20_0");
      run_div(6'd20, 6'd3,  6'd6,  6'd2,  1'b0, 6, "d20_3");

      // START pulses during RUN are ignored.
      @(negedge clk);
      start = 1'b1; a = 6'd45; b = 6'd6;
      @(posedge clk); #1;
      start = 1'b0;
      ndone = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 2 || k == 4) begin
            start = 1'b1; a = 6'd1; b = 6'd1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         if (done) ndone++;
      end
      check_val("ign_ndone", ndone, 1);
      check_val("ign_q", quot, 7);
      check_val("ign_r", rem, 3);

      // START held high: each acceptance is its own operation.
      @(negedge clk);
      a = hq_a[0]; b = hq_b[0]; start = 1'b1;
      idx = 0;
      cyc = 0;
      while (idx < 3 && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
         if (done) begin
            check_val($sformatf("held%0d_q", idx), quot, hq_q[idx]);
            check_val($sformatf("held%0d_r", idx), rem, hq_r[idx]);
            check_val($sformatf("held%0d_dz", idx), dz, hq_z[idx]);
            idx++;
            if (idx < 3) begin
               a = hq_a[idx]; b = hq_b[idx];
            end else begin
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      check_val("held_count", idx, 3);
      repeat (3) @(posedge clk);
      #1;

      // Asynchronous reset after the third iteration of 45/6.
      @(negedge clk);
      start = 1'b1; a = 6'd45; b = 6'd6;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check_val("arst_ready", ready, 1);
      check_val("arst_done", done, 0);
      check_val("arst_q", quot, 0);
      check_val("arst_r", rem, 0);
      check_val("arst_dz", dz, 0);
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      check_val("arst_no_done", ndone, 0);
      run_div(6'd50, 6'd7, 6'd7, 6'd1, 1'b0, 6, "d50_7");

      // Reset in the same cycle as START: nothing is accepted.
      @(negedge clk);
      start = 1'b1; a = 6'd9; b = 6'd2; rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      ndone = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      check_val("rst_start_no_done", ndone, 0);
      check_val("rst_start_ready", ready, 1);
      check_val("rst_start_q", quot, 0);

      // Sweep of every dividend against every nonzero divisor.
      for (int ai = 0; ai < 64; ai++) begin
         for (int bi = 1; bi < 64; bi++) begin
            ea = 6'(ai);
            eb = 6'(bi);
            run_div(ea, eb, 6'(ai / bi), 6'(ai % bi), 1'b0, 6,
                    $sformatf("sw%0d_%0d", ai, bi));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
